ram_port_rr_arbiter: RTL and testbench
======================================

Name: ram_port_rr_arbiter

Overview:
- Single-clock, round-robin arbiter that shares one port of a read-first, clock-enable, byte-enable RAM among NUM_REQ requesters.
- Each requester drives a valid/ready command channel and receives a valid/ready response channel.
- Every accepted command, read or write, produces exactly one response carrying the RAM read data for that address. For writes this is the pre-write (read-first) contents.
- Sits between bus-side masters (DMA, core, debug) and one port of the team's dual-port RAM macros.

Parameters:
- ADDR_WIDTH, 16, RAM word-address width.
- DATA_WIDTH, 64, RAM data width; multiple of 8.
- NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
- clk  input  1  clock for arbiter and RAM port
- rst  input  1  asynchronous active-high reset
- req_valid  input  NUM_REQ  command valid, one bit per requester
- req_ready  output  NUM_REQ  command accepted this cycle when valid&&ready
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed word addresses; requester i at [i*ADDR_WIDTH+:ADDR_WIDTH]
- req_we  input  NUM_REQ*DATA_WIDTH/8  packed byte enables; all-zero means read
- req_wrdata  input  NUM_REQ*DATA_WIDTH  packed write data
- resp_valid  output  NUM_REQ  response valid; at most one bit set
- resp_ready  input  NUM_REQ  response accepted
- resp_rddata  output  DATA_WIDTH  response data, shared; meaningful only for the requester whose resp_valid is set
- ram_en  output  1  RAM clock enable
- ram_we  output  DATA_WIDTH/8  RAM byte write enables
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_wrdata  output  DATA_WIDTH  RAM write data
- ram_rddata  input  DATA_WIDTH  RAM registered read data, valid one cycle after ram_en

Behaviour:
- Reset (async, active-high):
  - resp_valid=0, req_ready=0, ram_en=0.
  - State=IDLE, rr pointer=0, owner=0.
  - An in-flight response is discarded.
  - Outputs stay at reset values until the first clk edge after rst deasserts.
- States:
  - IDLE: no response outstanding.
  - BUSY: a response is outstanding for owner.
- can_issue = (state==IDLE) || (resp_valid[owner] && resp_ready[owner]).
- Arbitration (combinational):
  - Among set req_valid bits, grant the first index at or after rr pointer, wrapping modulo NUM_REQ.
  - req_ready[g] = can_issue for the granted g; all other req_ready bits are 0.
  - req_ready may depend on req_valid and resp_ready in the same cycle.
  - Requesters hold valid and payload stable until accepted.
- Issue (cycle T, on acceptance of g):
  - ram_en=1, ram_addr/ram_we/ram_wrdata = requester g's fields.
  - Register owner<=g, rr pointer<=(g+1) mod NUM_REQ, state<=BUSY.
  - ram_en=0 in every cycle with no acceptance; ram_we=0 whenever ram_en=0.
- Response (cycle T+1 onward):
  - resp_valid[owner]=1 while BUSY; resp_rddata=ram_rddata.
  - Data stays stable under backpressure because ram_en stays 0 until the response is accepted.
- Response completion:
  - When resp_valid&&resp_ready and there is no new acceptance in the same cycle: state<=IDLE.
  - When a new acceptance coincides (back-to-back): remain BUSY with the new owner.
  - Throughput 1 command/cycle; latency command-accept to resp_valid = 1 cycle.
- Address width: no arithmetic on addresses; passed through unmodified.
- Hazards:
  - The same requester may issue read-after-write to the same address back-to-back; the read returns the new data because the write completed in the earlier cycle.
  - Conflicts with the RAM's other port are the system's responsibility.
- Single requester: pointer still rotates; the grant remains that requester.
- rr pointer advances only on acceptance, never on idle cycles.

Test Plan:
- Read: reset, mem[0x10]=0xDEAD_BEEF_0000_0001, req0 read 0x10 -> req_ready[0] same cycle, ram_en=1 for one cycle, resp_valid[0] next cycle with resp_rddata=0xDEAD_BEEF_0000_0001.
- Fairness: req0 and req1 valid continuously, all reads, resp_ready=1 -> grants alternate 0,1,0,1 at one per cycle; no requester waits more than NUM_REQ-1 acceptances.
- Byte-enable: req1 writes 0x1122334455667788 to 0x20 with we=0x0F over prior 0 -> write response returns 0; subsequent read returns 0x0000000055667788.
- Backpressure: resp_ready[0]=0 for 3 cycles after a read while req1 is valid -> resp_rddata stable, ram_en=0, req_ready all 0; in the cycle resp_ready[0]=1, req1 is accepted.
- Reset mid-op: assert rst while resp_valid[1]=1 -> resp_valid=0 and ram_en=0 immediately (async); after release the first grant goes to req0.
- Idle: no req_valid for 10 cycles -> ram_en=0 throughout, rr pointer unchanged.

Source files
------------

// File: rtl/ram_port_rr_arbiter.sv
// Round-robin arbiter sharing one read-first, byte-enable RAM port among NUM_REQ
// requesters; every accepted command returns exactly one response with the RAM read data.
module ram_port_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wrdata,
  output logic [NUM_REQ-1:0]                  resp_valid,
  input  logic [NUM_REQ-1:0]                  resp_ready,
  output logic [DATA_WIDTH-1:0]               resp_rddata,
  output logic                                ram_en,
  output logic [DATA_WIDTH/8-1:0]             ram_we,
  output logic [ADDR_WIDTH-1:0]               ram_addr,
  output logic [DATA_WIDTH-1:0]               ram_wrdata,
  input  logic [DATA_WIDTH-1:0]               ram_rddata
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_q;
  logic               rst_done_q;

  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               can_issue;
  logic               accept;
  logic [IDX_W-1:0]   rr_d;

  // Rotating-priority search: the lowest offset from rr_q with a valid request wins.
  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + (NUM_REQ - 1 - k);
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req_valid[IDX_W'(idx)]) begin
        gnt_idx = IDX_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

  // rst_done_q holds issue off until the first edge after reset release.
  always_comb begin
    can_issue = rst_done_q && ((state_q == IDLE) || resp_ready[owner_q]);
    accept    = can_issue && gnt_any;
    rr_d      = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // RAM port driven straight from the granted requester in the acceptance cycle.
  always_comb begin
    ram_en     = accept;
    ram_addr   = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    ram_wrdata = req_wrdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    ram_we     = '0;
    if (accept) begin
      ram_we = req_we[gnt_idx*BE_W +: BE_W];
    end
  end

  always_comb begin
    resp_valid  = '0;
    resp_rddata = ram_rddata;
    if (state_q == BUSY) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) begin
        state_q <= BUSY;
        owner_q <= gnt_idx;
        rr_q    <= rr_d;
      end else if ((state_q == BUSY) && resp_ready[owner_q]) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_rr_arbiter.sv
// Scoreboard bench for ram_port_rr_arbiter: directed commands push expected responses,
// a forked monitor pops and compares on every response handshake.
module tb_ram_port_rr_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 2;
  localparam int unsigned BW = DW / 8;

  localparam logic [63:0] D_DEAD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D_BE   = 64'h0000_0000_5566_7788;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_we;
  logic [NR*DW-1:0]  req_wrdata;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready;
  logic [DW-1:0]     resp_rddata;
  logic              ram_en;
  logic [BW-1:0]     ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wrdata;
  logic [DW-1:0]     ram_rddata = '0;

  typedef struct {
    int unsigned who;
    logic [63:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_port_rr_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wrdata (req_wrdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rddata(resp_rddata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wrdata (ram_wrdata),
    .ram_rddata (ram_rddata)
  );

  // Read-first, byte-enable RAM with registered read data.
  logic [63:0] mem [0:65535] = '{default: '0};
  logic [63:0] ram_new;

  always_comb begin
    ram_new = mem[ram_addr];
    for (int b = 0; b < 8; b++) begin
      if (ram_we[b]) ram_new[b*8 +: 8] = ram_wrdata[b*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rddata     <= mem[ram_addr];
      mem[ram_addr]  <= ram_new;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [AW-1:0] a,
                       input logic [BW-1:0] we, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_we[i*BW +: BW]    = we;
    req_wrdata[i*DW +: DW] = d;
  endtask

  task automatic push_exp(input int unsigned who, input logic [63:0] data);
    exp_t e;
    e.who  = who;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops one expectation per response handshake and checks requester and data.
  task automatic monitor();
    exp_t        e;
    int unsigned who;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (resp_valid != '0) chk("resp_onehot", 64'($countones(resp_valid)), 64'd1);
        if (!ram_en) chk("ram_we_idle", 64'(ram_we), 64'd0);
        if ((resp_valid & resp_ready) != '0) begin
          who = 0;
          for (int i = 0; i < NR; i++) if (resp_valid[i]) who = i;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected: got response for req%0d, none expected", who);
          end else begin
            e = expq.pop_front();
            chk("resp_who", 64'(who), 64'(e.who));
            chk("resp_data", resp_rddata, e.data);
          end
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_we     = '0;
    req_wrdata = '0;
    resp_ready = '1;
    fork
      monitor();
    join_none

    // Reset with requests pending: nothing may be granted.
    drive(0, 1'b1, 16'h0010, 8'h00, '0);
    drive(1, 1'b1, 16'h0020, 8'h00, '0);
    repeat (2) step();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Preload mem[0x10] through the port; write returns old contents (0).
    drive(0, 1'b1, 16'h0010, 8'hFF, D_DEAD);
    push_exp(0, 64'd0);
    @(negedge clk);
    chk("wr_req_ready", 64'(req_ready), 64'd1);
    chk("wr_ram_en", 64'(ram_en), 64'd1);
    chk("wr_ram_we", 64'(ram_we), 64'hFF);
    chk("wr_ram_addr", 64'(ram_addr), 64'h10);
    chk("wr_ram_wrdata", ram_wrdata, D_DEAD);
    step();
    drive(0, 1'b0, 16'h0010, 8'h00, '0);
    step();

    // Single read: accepted same cycle, response next cycle.
    drive(0, 1'b1, 16'h0010, 8'h00, '0);
    push_exp(0, D_DEAD);
    @(negedge clk);
    chk("rd_req_ready", 64'(req_ready), 64'd1);
    chk("rd_ram_en", 64'(ram_en), 64'd1);
    chk("rd_ram_we", 64'(ram_we), 64'd0);
    step();
    drive(0, 1'b0, 16'h0010, 8'h00, '0);
    @(negedge clk);
    chk("rd_ram_en_off", 64'(ram_en), 64'd0);
    chk("rd_resp_valid", 64'(resp_valid), 64'd1);
    chk("rd_resp_data", resp_rddata, D_DEAD);
    step();

    // Byte-enable write, then back-to-back read-after-write from the same requester.
    drive(1, 1'b1, 16'h0020, 8'h0F, 64'h1122_3344_5566_7788);
    push_exp(1, 64'd0);
    @(negedge clk);
    chk("be_req_ready", 64'(req_ready), 64'd2);
    chk("be_ram_we", 64'(ram_we), 64'h0F);
    step();
    drive(1, 1'b1, 16'h0020, 8'h00, '0);
    push_exp(1, D_BE);
    @(negedge clk);
    chk("raw_req_ready", 64'(req_ready), 64'd2);
    step();
    drive(1, 1'b0, 16'h0020, 8'h00, '0);
    step();

    // Fairness: both requesters always valid, grants alternate 0,1,0,1,...
    drive(0, 1'b1, 16'h0010, 8'h00, '0);
    drive(1, 1'b1, 16'h0020, 8'h00, '0);
    for (int k = 0; k < 6; k++) begin
      push_exp(k % 2, (k % 2 == 0) ? D_DEAD : D_BE);
      @(negedge clk);
      chk("fair_grant", 64'(req_ready), 64'(1 << (k % 2)));
      step();
    end
    req_valid = '0;
    step();

    // Backpressure: held response keeps data stable and blocks all grants.
    resp_ready = 2'b10;
    drive(0, 1'b1, 16'h0010, 8'h00, '0);
    push_exp(0, D_DEAD);
    @(negedge clk);
    chk("bp_first_grant", 64'(req_ready), 64'd1);
    step();
    drive(0, 1'b0, 16'h0010, 8'h00, '0);
    drive(1, 1'b1, 16'h0020, 8'h00, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_ram_en", 64'(ram_en), 64'd0);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_data", resp_rddata, D_DEAD);
      step();
    end
    resp_ready = 2'b11;
    push_exp(1, D_BE);
    @(negedge clk);
    chk("bp_release_grant", 64'(req_ready), 64'd2);
    chk("bp_release_en", 64'(ram_en), 64'd1);
    step();
    drive(1, 1'b0, 16'h0020, 8'h00, '0);
    step();

    // Reset mid-operation: the held response for req1 is discarded.
    resp_ready = 2'b00;
    drive(1, 1'b1, 16'h0020, 8'h00, '0);
    @(negedge clk);
    chk("mid_grant", 64'(req_ready), 64'd2);
    step();
    drive(1, 1'b0, 16'h0020, 8'h00, '0);
    @(negedge clk);
    chk("mid_resp_valid", 64'(resp_valid), 64'd2);
    #2;
    drive(0, 1'b1, 16'h0010, 8'h00, '0);
    drive(1, 1'b1, 16'h0020, 8'h00, '0);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_ram_en", 64'(ram_en), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd0);
    step();
    resp_ready = 2'b11;
    push_exp(0, D_DEAD);
    @(negedge clk);
    chk("post_rst_grant", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    step();

    // Idle: no grants and pointer stays at 1.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("idle_ram_en", 64'(ram_en), 64'd0);
      step();
    end
    drive(0, 1'b1, 16'h0010, 8'h00, '0);
    drive(1, 1'b1, 16'h0020, 8'h00, '0);
    push_exp(1, D_BE);
    @(negedge clk);
    chk("idle_after_grant1", 64'(req_ready), 64'd2);
    step();
    push_exp(0, D_DEAD);
    @(negedge clk);
    chk("idle_after_grant0", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    step();

    for (int k = 0; k < 20; k++) begin
      if (expq.size() == 0) break;
      step();
    end
    chk("drain_queue", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
